// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake and status bundle between the datapath and the FIFO controller.
// The master modport belongs to the datapath, and the slave modport belongs to the controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              udf;

    modport master (
        output push, push_data, pop,
        input  pop_data, pop_valid, full, empty, count, ovf, udf
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, pop_valid, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns an external dual-port RAM with a registered read port into a queue.
// It owns the pointers, the occupancy count and the sticky error flags. The RAM only responds to it.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    ram_fifo_ctrl_if.slave      fifo,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_wr_add,
    output logic [ADDR_W-1:0]   ram_rd_add,
    output logic [DATA_W-1:0]   ram_d,
    input  logic [DATA_W-1:0]   ram_q
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              pop_valid_q;
    logic              ovf_q;
    logic              udf_q;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    // The flags come from the count and not from the pointers. This is because the pointers are equal both when the FIFO is empty and when it is full.
    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign push_ok = fifo.push & ~full;
    assign pop_ok  = fifo.pop & ~empty;

    assign ram_we     = push_ok;
    assign ram_wr_add = wr_ptr;
    assign ram_d      = fifo.push_data;
    assign ram_rd_add = rd_ptr;

    assign fifo.pop_data  = ram_q;
    assign fifo.pop_valid = pop_valid_q;
    assign fifo.full      = full;
    assign fifo.empty     = empty;
    assign fifo.count     = count_q;
    assign fifo.ovf       = ovf_q;
    assign fifo.udf       = udf_q;

    // NOTE: the asynchronous reset clears only the control state. The external RAM keeps its contents, but those contents are unreachable until they are rewritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments here so that every register sees the pre-edge values of its peers.
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            pop_valid_q <= pop_ok;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= ovf_q | (fifo.push & full);
            udf_q <= udf_q | (fifo.pop & empty);
        end
    end
endmodule
